// File: rtl/hdmi_422_to_444.sv
// -----------------------------------------------------------------------------
// hdmi_422_to_444
//
// Converts a 4:2:2 YCbCr pixel stream into 4:4:4. Each active run (i_de high)
// is split into pairs: the even pixel carries Cb, the odd pixel carries Cr.
// Both pixels of a pair output the same (Cb, Cr). A final unpaired pixel
// outputs its own Cb with BLANK_C as Cr, and o_odd_line pulses once.
//
// Optional feature macro: CHROMA_AVG_EN
//   When defined, odd pixels output the rounded average of their own pair's
//   chroma and the next pair's chroma. A third pipeline stage is added
//   (latency 3 instead of 2). Without it, latency is 2.
//
// Parameters:
//   BLANK_Y   luma driven while o_de is low
//   BLANK_C   chroma driven while o_de is low
//
// Ports:
//   i_clk       pixel clock (rising edge)
//   i_rst       asynchronous active-high reset
//   i_hsync     horizontal sync in
//   i_vsync     vertical sync in
//   i_de        active-video enable in
//   i_data      [7:0]=Y, [15:8]=Cb (even pixel) / Cr (odd pixel)
//   o_hsync     i_hsync delayed by the pipeline latency
//   o_vsync     i_vsync delayed by the pipeline latency
//   o_de        i_de delayed by the pipeline latency
//   o_y         output luma
//   o_cb        output blue-difference chroma
//   o_cr        output red-difference chroma
//   o_odd_line  one-cycle pulse in the first o_de-low cycle after a run of
//               odd length
// -----------------------------------------------------------------------------
module hdmi_422_to_444 #(
    parameter logic [7:0] BLANK_Y = 8'h10,
    parameter logic [7:0] BLANK_C = 8'h80
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_de,
    input  logic [15:0] i_data,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [7:0]  o_y,
    output logic [7:0]  o_cb,
    output logic [7:0]  o_cr,
    output logic        o_odd_line
);

    // Phase of the pixel currently on the input: 0 = Cb, 1 = Cr.
    logic       phase;

    // Stage 1: raw 4:2:2 pixel.
    logic       s1_de;
    logic       s1_hs;
    logic       s1_vs;
    logic       s1_phase;
    logic [7:0] s1_y;
    logic [7:0] s1_c;
    // Chroma of the pixel that occupied stage 1 one cycle earlier. For an
    // odd pixel this is the Cb of its own pair (the even pixel always
    // immediately precedes it within a run).
    logic [7:0] s1_prev_c;

    // Stage 2: reconstructed 4:4:4 pixel.
    logic       s2_de;
    logic       s2_hs;
    logic       s2_vs;
    logic [7:0] s2_y;
    logic [7:0] s2_cb;
    logic [7:0] s2_cr;
    logic       s2_unp;

    // Stage 2 chroma selection.
    logic [7:0] s2_cb_s;
    logic [7:0] s2_cr_s;
    logic       s2_unp_s;

    // Unpaired-pixel flag at the output stage, source of o_odd_line.
    logic       last_unp;

    // Input phase tracking: restarts at 0 after every i_de-low cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phase <= 1'b0;
        end else if (i_de) begin
            phase <= ~phase;
        end else begin
            phase <= 1'b0;
        end
    end

    // Stage 1 register: capture the incoming pixel and its phase.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_de     <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_phase  <= 1'b0;
            s1_y      <= BLANK_Y;
            s1_c      <= BLANK_C;
            s1_prev_c <= BLANK_C;
        end else begin
            s1_de     <= i_de;
            s1_hs     <= i_hsync;
            s1_vs     <= i_vsync;
            s1_phase  <= phase;
            s1_y      <= i_de ? i_data[7:0]  : BLANK_Y;
            s1_c      <= i_de ? i_data[15:8] : BLANK_C;
            s1_prev_c <= s1_c;
        end
    end

    // Pair the chroma samples. An even pixel takes Cr from the input, which
    // holds the odd pixel of the same pair if the run continues; if i_de has
    // dropped, the pixel is unpaired and gets BLANK_C.
    always_comb begin
        s2_cb_s  = BLANK_C;
        s2_cr_s  = BLANK_C;
        s2_unp_s = 1'b0;
        if (!s1_de) begin
            s2_cb_s  = BLANK_C;
            s2_cr_s  = BLANK_C;
            s2_unp_s = 1'b0;
        end else if (!s1_phase) begin
            s2_cb_s = s1_c;
            if (i_de) begin
                s2_cr_s  = i_data[15:8];
                s2_unp_s = 1'b0;
            end else begin
                s2_cr_s  = BLANK_C;
                s2_unp_s = 1'b1;
            end
        end else begin
            s2_cb_s  = s1_prev_c;
            s2_cr_s  = s1_c;
            s2_unp_s = 1'b0;
        end
    end

`ifdef CHROMA_AVG_EN
    logic       s2_odd;

    // Stage 3: averaged 4:4:4 pixel.
    logic       s3_de;
    logic       s3_hs;
    logic       s3_vs;
    logic [7:0] s3_y;
    logic [7:0] s3_cb;
    logic [7:0] s3_cr;
    logic       s3_unp;

    logic       next_pair_s;
    logic [8:0] sum_cb_s;
    logic [8:0] sum_cr_s;
    logic [7:0] s3_cb_s;
    logic [7:0] s3_cr_s;
`endif

    // Stage 2 register: 4:4:4 pixel with pair-replicated chroma.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_de  <= 1'b0;
            s2_hs  <= 1'b0;
            s2_vs  <= 1'b0;
            s2_y   <= BLANK_Y;
            s2_cb  <= BLANK_C;
            s2_cr  <= BLANK_C;
            s2_unp <= 1'b0;
`ifdef CHROMA_AVG_EN
            s2_odd <= 1'b0;
`endif
        end else begin
            s2_de  <= s1_de;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_y   <= s1_de ? s1_y : BLANK_Y;
            s2_cb  <= s2_cb_s;
            s2_cr  <= s2_cr_s;
            s2_unp <= s2_unp_s;
`ifdef CHROMA_AVG_EN
            s2_odd <= s1_de & s1_phase;
`endif
        end
    end

`ifdef CHROMA_AVG_EN
    // Average an odd pixel's chroma with the next pair. While stage 2 holds
    // odd pixel 2k+1, stage 1 holds pixel 2k+2 (Cb_{k+1}) and the input
    // holds pixel 2k+3 (Cr_{k+1}). If either is missing the pair is simply
    // replicated. Sums are 9 bits wide so the carry is kept before rounding.
    always_comb begin
        next_pair_s = s1_de & ~s1_phase & i_de;
        sum_cb_s    = {1'b0, s2_cb} + {1'b0, s1_c} + 9'd1;
        sum_cr_s    = {1'b0, s2_cr} + {1'b0, i_data[15:8]} + 9'd1;
        s3_cb_s     = s2_cb;
        s3_cr_s     = s2_cr;
        if (s2_de && s2_odd && next_pair_s) begin
            s3_cb_s = sum_cb_s[8:1];
            s3_cr_s = sum_cr_s[8:1];
        end else begin
            s3_cb_s = s2_cb;
            s3_cr_s = s2_cr;
        end
    end

    // Stage 3 register: final output pixel.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s3_de  <= 1'b0;
            s3_hs  <= 1'b0;
            s3_vs  <= 1'b0;
            s3_y   <= BLANK_Y;
            s3_cb  <= BLANK_C;
            s3_cr  <= BLANK_C;
            s3_unp <= 1'b0;
        end else begin
            s3_de  <= s2_de;
            s3_hs  <= s2_hs;
            s3_vs  <= s2_vs;
            s3_y   <= s2_y;
            s3_cb  <= s3_cb_s;
            s3_cr  <= s3_cr_s;
            s3_unp <= s2_unp;
        end
    end

    assign last_unp = s3_unp;
    assign o_de     = s3_de;
    assign o_hsync  = s3_hs;
    assign o_vsync  = s3_vs;
    assign o_y      = s3_y;
    assign o_cb     = s3_cb;
    assign o_cr     = s3_cr;
`else
    assign last_unp = s2_unp;
    assign o_de     = s2_de;
    assign o_hsync  = s2_hs;
    assign o_vsync  = s2_vs;
    assign o_y      = s2_y;
    assign o_cb     = s2_cb;
    assign o_cr     = s2_cr;
`endif

    // Odd-line pulse: an unpaired pixel is always the last of its run, so
    // delaying its flag by one cycle lands on the first o_de-low cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_odd_line <= 1'b0;
        end else begin
            o_odd_line <= last_unp;
        end
    end

endmodule

// File: tb/tb_hdmi_422_to_444.sv
// -----------------------------------------------------------------------------
// tb_hdmi_422_to_444
//
// Directed bench for hdmi_422_to_444. A table of input cycles with the
// expected output for each cycle's pixel is streamed through the design and
// each row is compared once it emerges from the pipeline. Hand-written
// sequences cover reset behaviour and reset asserted mid-line.
// -----------------------------------------------------------------------------
module tb_hdmi_422_to_444;

`ifdef CHROMA_AVG_EN
    localparam int L = 3;
`else
    localparam int L = 2;
`endif
    localparam int NV = 21;

    logic        clk;
    logic        rst;
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] data;
    logic        o_hs;
    logic        o_vs;
    logic        o_de;
    logic [7:0]  o_y;
    logic [7:0]  o_cb;
    logic [7:0]  o_cr;
    logic        o_odd;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        de;
        logic        hs;
        logic        vs;
        logic [15:0] data;
        logic        e_de;
        logic        e_hs;
        logic        e_vs;
        logic [7:0]  e_y;
        logic [7:0]  e_cb;
        logic [7:0]  e_cr;
        logic        e_odd;
    } vec_t;

    vec_t tbl [NV];

    hdmi_422_to_444 dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_hsync    (hs),
        .i_vsync    (vs),
        .i_de       (de),
        .i_data     (data),
        .o_hsync    (o_hs),
        .o_vsync    (o_vs),
        .o_de       (o_de),
        .o_y        (o_y),
        .o_cb       (o_cb),
        .o_cr       (o_cr),
        .o_odd_line (o_odd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t idle_row(input logic h, input logic v, input logic odd);
        vec_t r;
        r.de = 1'b0; r.hs = h; r.vs = v; r.data = 16'h0000;
        r.e_de = 1'b0; r.e_hs = h; r.e_vs = v;
        r.e_y = 8'h10; r.e_cb = 8'h80; r.e_cr = 8'h80; r.e_odd = odd;
        return r;
    endfunction

    function automatic vec_t pix_row(input logic [15:0] d, input logic [7:0] ey,
                                     input logic [7:0] ecb, input logic [7:0] ecr);
        vec_t r;
        r.de = 1'b1; r.hs = 1'b0; r.vs = 1'b0; r.data = d;
        r.e_de = 1'b1; r.e_hs = 1'b0; r.e_vs = 1'b0;
        r.e_y = ey; r.e_cb = ecb; r.e_cr = ecr; r.e_odd = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, " de"},   {7'd0, o_de},  8'h00);
        chk({tag, " hs"},   {7'd0, o_hs},  8'h00);
        chk({tag, " vs"},   {7'd0, o_vs},  8'h00);
        chk({tag, " odd"},  {7'd0, o_odd}, 8'h00);
        chk({tag, " y"},    o_y,  8'h10);
        chk({tag, " cb"},   o_cb, 8'h80);
        chk({tag, " cr"},   o_cr, 8'h80);
    endtask

    task automatic chk_pix(input string tag, input logic [7:0] ey,
                           input logic [7:0] ecb, input logic [7:0] ecr);
        chk({tag, " de"}, {7'd0, o_de}, 8'h01);
        chk({tag, " y"},  o_y,  ey);
        chk({tag, " cb"}, o_cb, ecb);
        chk({tag, " cr"}, o_cr, ecr);
    endtask

    task automatic drive(input logic d, input logic [15:0] v);
        de   = d;
        data = v;
        hs   = 1'b0;
        vs   = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0; data = 16'h0000;

        // Stimulus table: input cycle and the output expected for it.
        tbl[0]  = idle_row(1'b0, 1'b0, 1'b0);
        tbl[1]  = idle_row(1'b1, 1'b0, 1'b0);
        tbl[2]  = idle_row(1'b0, 1'b0, 1'b0);
        tbl[3]  = idle_row(1'b0, 1'b1, 1'b0);
        tbl[4]  = idle_row(1'b0, 1'b0, 1'b0);
        tbl[5]  = pix_row(16'h0FDD, 8'hDD, 8'h0F, 8'h8B);
        tbl[6]  = pix_row(16'h8BDD, 8'hDD, 8'h0F, 8'h8B);
        tbl[7]  = idle_row(1'b0, 1'b0, 1'b0);
        tbl[8]  = pix_row(16'h80EB, 8'hEB, 8'h80, 8'h80);
        tbl[9]  = pix_row(16'h80EB, 8'hEB, 8'h80, 8'h80);
        tbl[10] = pix_row(16'h9ABC, 8'hBC, 8'h9A, 8'h80);
        tbl[11] = idle_row(1'b0, 1'b0, 1'b1);
        tbl[12] = idle_row(1'b0, 1'b0, 1'b0);
        tbl[13] = pix_row(16'h1234, 8'h34, 8'h12, 8'h80);
        tbl[14] = idle_row(1'b0, 1'b0, 1'b1);
        tbl[15] = pix_row(16'h0F11, 8'h11, 8'h0F, 8'h8B);
`ifdef CHROMA_AVG_EN
        tbl[16] = pix_row(16'h8B22, 8'h22, 8'h55, 8'h4D);
`else
        tbl[16] = pix_row(16'h8B22, 8'h22, 8'h0F, 8'h8B);
`endif
        tbl[17] = pix_row(16'h9A33, 8'h33, 8'h9A, 8'h0F);
        tbl[18] = pix_row(16'h0F44, 8'h44, 8'h9A, 8'h0F);
        tbl[19] = idle_row(1'b0, 1'b0, 1'b0);
        tbl[20] = idle_row(1'b0, 1'b0, 1'b0);

        // Reset held: outputs blank.
        repeat (3) @(negedge clk);
        chk_blank("in_reset");
        rst = 1'b0;

        // Idle after reset.
        repeat (L + 2) @(negedge clk);
        chk_blank("idle");

        // Stream the table; row j-L emerges at the j-th sample point.
        for (int j = 0; j < NV + L; j++) begin
            @(negedge clk);
            if (j >= L) begin
                chk($sformatf("row%0d de", j - L),  {7'd0, o_de},  {7'd0, tbl[j - L].e_de});
                chk($sformatf("row%0d hs", j - L),  {7'd0, o_hs},  {7'd0, tbl[j - L].e_hs});
                chk($sformatf("row%0d vs", j - L),  {7'd0, o_vs},  {7'd0, tbl[j - L].e_vs});
                chk($sformatf("row%0d odd", j - L), {7'd0, o_odd}, {7'd0, tbl[j - L].e_odd});
                chk($sformatf("row%0d y", j - L),   o_y,  tbl[j - L].e_y);
                chk($sformatf("row%0d cb", j - L),  o_cb, tbl[j - L].e_cb);
                chk($sformatf("row%0d cr", j - L),  o_cr, tbl[j - L].e_cr);
            end
            if (j < NV) begin
                de   = tbl[j].de;
                hs   = tbl[j].hs;
                vs   = tbl[j].vs;
                data = tbl[j].data;
            end else begin
                drive(1'b0, 16'h0000);
            end
        end

        // Reset asserted mid-line: three pixels in flight, the third at phase 0.
        @(negedge clk); drive(1'b1, 16'h0F11);
        @(negedge clk); drive(1'b1, 16'h8B22);
        @(negedge clk); drive(1'b1, 16'h5566);
        @(negedge clk); drive(1'b0, 16'h0000);
        rst = 1'b1;
        #1;
        chk_blank("rst_mid");
        @(negedge clk);
        chk_blank("rst_hold");
        rst = 1'b0;
        // New line starts: first pixel must be taken as Cb.
        drive(1'b1, 16'h7788);
        for (int c = 1; c <= L + 1; c++) begin
            @(negedge clk);
            if (c < L) begin
                chk_blank($sformatf("restart_wait%0d", c));
            end else if (c == L) begin
                chk_pix("restart_p0", 8'h88, 8'h77, 8'h99);
            end else begin
                chk_pix("restart_p1", 8'hAA, 8'h77, 8'h99);
            end
            if (c == 1) begin
                drive(1'b1, 16'h99AA);
            end else begin
                drive(1'b0, 16'h0000);
            end
        end
        @(negedge clk);
        chk_blank("restart_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hdmi_422_to_444.md
HDMI_422_TO_444 -- requirements
Module: hdmi_422_to_444

Interface
REQ-001 Parameter BLANK_Y, default 8'h10, luma driven on o_y while o_de is low.
REQ-002 Parameter BLANK_C, default 8'h80, chroma driven on o_cb/o_cr while o_de is low.
REQ-003 i_clk  in  1  pixel clock; the single clock; all logic SHALL be rising-edge on it.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_hsync  in  1  horizontal sync from the 4:2:2 source.
REQ-006 i_vsync  in  1  vertical sync from the 4:2:2 source.
REQ-007 i_de  in  1  active-video enable.
REQ-008 i_data  in  16  [7:0]=Y; [15:8]=Cb on even pixel, Cr on odd pixel of the active run.
REQ-009 o_hsync  out  1  i_hsync delayed by pipeline latency L.
REQ-010 o_vsync  out  1  i_vsync delayed by L.
REQ-011 o_de  out  1  i_de delayed by L.
REQ-012 o_y / o_cb / o_cr  out  8 each  4:4:4 YCbCr pixel.
REQ-013 o_odd_line  out  1  one-cycle pulse: active run ended with an unpaired Cb pixel.

Function
REQ-014 Phase SHALL be 0 (Cb) on the first i_de-high cycle after i_de low, then toggle on every i_de-high cycle; pair k = pixels 2k (Cb_k), 2k+1 (Cr_k).
REQ-015 Latency L SHALL be exactly 2 cycles without CHROMA_AVG_EN, exactly 3 with it, identical for o_hsync, o_vsync, o_de, o_y, o_cb, o_cr.
REQ-016 o_y SHALL equal i_data[7:0] of the corresponding input pixel, unmodified.
REQ-017 Pixels 2k and 2k+1 SHALL both output Cb=Cb_k, Cr=Cr_k (except as modified by REQ-026).
REQ-018 Unpaired final pixel (run of odd length) SHALL output Cb=Cb_k, Cr=BLANK_C.
REQ-019 o_odd_line SHALL pulse for one cycle, aligned with o_de falling, when the ended run had odd length; otherwise 0.
REQ-020 While o_de=0: o_y=BLANK_Y, o_cb=o_cr=BLANK_C.
REQ-021 Chroma SHALL never be taken across an i_de-low gap; each active run is paired independently.
REQ-022 A single-cycle i_de pulse SHALL be treated as a run of length 1 (REQ-018, REQ-019 apply).
REQ-023 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-024 While i_rst=1: o_de=0, o_hsync=0, o_vsync=0, o_odd_line=0, o_y=BLANK_Y, o_cb=o_cr=BLANK_C; all pipeline stages hold the blank state; phase=0.
REQ-025 Reset asserted mid-line SHALL discard all in-flight pixels; after release the first i_de-high cycle is phase 0, and outputs stay blank until it emerges L cycles later.

Configuration
REQ-026 Macro CHROMA_AVG_EN: when defined, odd pixel 2k+1 SHALL output Cb=(Cb_k+Cb_{k+1}+1)>>1 and Cr=(Cr_k+Cr_{k+1}+1)>>1, computed with a 9-bit sum; if pair k+1 is absent or incomplete in the run, pair k SHALL be replicated; even pixels are unchanged; L=3.
REQ-027 When CHROMA_AVG_EN is undefined, the averaging logic and the third pipeline stage SHALL NOT be built, and REQ-017 applies with L=2.

Verification
REQ-028 Reset, then idle with i_de=0 -> o_de=0, o_y=8'h10, o_cb=o_cr=8'h80, o_odd_line=0.
REQ-029 Macro off; active run of 2 pixels, i_data=16'h0FDD then 16'h8BDD -> output cycles t+2 and t+3 both give Y=DD, Cb=0F, Cr=8B, o_de=1.
REQ-030 Macro off; run of 3 pixels, 16'h80EB, 16'h80EB, 16'h9ABC -> third output Y=BC, Cb=9A, Cr=80; o_odd_line=1 for exactly one cycle as o_de falls.
REQ-031 Macro on; pairs (Cb,Cr)=(0F,8B) then (9A,0F), 4 pixels -> pixel 1 gives Cb=55, Cr=4D; pixel 3 gives Cb=9A, Cr=0F (replicated); L=3.
REQ-032 Toggle i_hsync/i_vsync single cycles during blanking -> o_hsync/o_vsync reproduce them exactly L cycles later.
REQ-033 Assert i_rst for 1 cycle mid-run, then restart the line -> outputs blank immediately; the first new pixel is treated as Cb (phase 0) and appears L cycles after its input.
